// File: rtl/jesd204_reset_sequencer_if.sv
// jesd204_reset_sequencer_if: reset requests and ready inputs,
// reset pins and status outputs of the JESD204 reset sequencer.
interface jesd204_reset_sequencer_if #(
  parameter int NUM_CH = 2
);
  logic              master_reset;
  logic [NUM_CH-1:0] ch_reset;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] rst_out;
  logic              busy;
  logic              seq_done;
  logic [NUM_CH-1:0] timeout_err;

  modport master (
    output master_reset,
    output ch_reset,
    output ch_ready,
    input  rst_out,
    input  busy,
    input  seq_done,
    input  timeout_err
  );

  modport slave (
    input  master_reset,
    input  ch_reset,
    input  ch_ready,
    output rst_out,
    output busy,
    output seq_done,
    output timeout_err
  );
endinterface

// File: rtl/jesd204_reset_sequencer.sv
// jesd204_reset_sequencer: per-channel reset pulse generator and
// ascending-order release sequencer for the JESD204 RX path.
module jesd204_reset_sequencer #(
  parameter int                NUM_CH          = 2,
  parameter int                PULSE_LEN       = 4800,
  parameter int                CNT_W           = 16,
  parameter int                RELEASE_GAP     = 16,
  parameter logic [NUM_CH-1:0] READY_MASK      = '0,
  parameter int                RDY_TIMEOUT     = 1000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = NUM_CH'(2'b10)
) (
  input logic                      m_axi_aclk,
  input logic                      m_axi_aresetn,
  jesd204_reset_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PLS_LD  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] RDY_LD  = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(RELEASE_GAP - 1);
  // The RELEASE cycle itself is the first cycle of the gap.
  localparam logic [CNT_W-1:0] GAP_SLD =
    CNT_W'((RELEASE_GAP > 1) ? RELEASE_GAP - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD_PEND,
    S_HOLD,
    S_REL,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] ra_q, ra_d;
  logic [CNT_W-1:0]  pcnt_q [NUM_CH];
  logic [CNT_W-1:0]  pcnt_d [NUM_CH];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] terr_q, terr_d;
  logic              mr_q;
  logic [NUM_CH-1:0] chr_q;

  logic              m_edge;
  logic [NUM_CH-1:0] ch_edge;
  logic              last_ch;
  logic              rdy_cur;
  logic              rdy_to;

  assign m_edge  = bus.master_reset & ~mr_q;
  assign ch_edge = bus.ch_reset & ~chr_q;
  assign last_ch = (idx_q == LAST);
  assign rdy_cur = bus.ch_ready[idx_q];
  assign rdy_to  = (state_q == S_WAIT) && !rdy_cur
                && (cnt_q == '0);

  assign bus.rst_out     = ra_q ^ ACTIVE_LOW_MASK;
  assign bus.busy        = busy_q;
  assign bus.seq_done    = done_q;
  assign bus.timeout_err = terr_q;

  // State, counters, edge history and registered outputs.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q <= S_HOLD_PEND;
      cnt_q   <= '0;
      idx_q   <= '0;
      ra_q    <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      terr_q  <= '0;
      mr_q    <= 1'b0;
      chr_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ra_q    <= ra_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      mr_q    <= bus.master_reset;
      chr_q   <= bus.ch_reset;
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt_q[i] <= pcnt_d[i];
      end
    end
  end

  // Sequence walk: master edge always restarts at HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (m_edge) begin
      state_d = S_HOLD;
      cnt_d   = PLS_LD;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_HOLD_PEND: begin
          state_d = S_HOLD;
          cnt_d   = PLS_LD;
          idx_d   = '0;
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d = S_REL;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_REL: begin
          if (READY_MASK[idx_q]) begin
            state_d = S_WAIT;
            cnt_d   = RDY_LD;
          end else if (last_ch) begin
            state_d = S_DONE;
          end else if (RELEASE_GAP == 1) begin
            state_d = S_REL;
            idx_d   = idx_q + IDX_ONE;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_SLD;
          end
        end
        S_WAIT: begin
          if (rdy_cur || cnt_q == '0) begin
            if (last_ch) begin
              state_d = S_DONE;
            end else begin
              state_d = S_GAP;
              cnt_d   = GAP_LD;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_REL;
            idx_d   = idx_q + IDX_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Reset vector, channel pulses, flags and status outputs.
  always_comb begin
    ra_d   = ra_q;
    terr_d = terr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pcnt_d[i] = pcnt_q[i];
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (m_edge) begin
      ra_d   = '1;
      terr_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt_d[i] = '0;
      end
    end else if (state_q == S_IDLE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_edge[i]) begin
          ra_d[i]   = 1'b1;
          pcnt_d[i] = PLS_LD;
        end else if (ra_q[i]) begin
          if (pcnt_q[i] == '0) begin
            ra_d[i] = 1'b0;
          end else begin
            pcnt_d[i] = pcnt_q[i] - CNT_ONE;
          end
        end
      end
    end else begin
      if (state_d == S_REL) begin
        ra_d[idx_d] = 1'b0;
      end
      if (rdy_to) begin
        terr_d[idx_q] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jesd204_reset_sequencer.sv
// tb_jesd204_reset_sequencer: directed checks of pulse timing,
// release order, ready wait, timeout and restart behaviour.
module tb_jesd204_reset_sequencer;

  logic clk = 1'b0;
  logic rstn_a;
  logic rstn_b;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  jesd204_reset_sequencer_if #(.NUM_CH(2)) ifa ();
  jesd204_reset_sequencer_if #(.NUM_CH(2)) ifb ();

  jesd204_reset_sequencer #(
    .NUM_CH(2), .PULSE_LEN(8), .CNT_W(16),
    .RELEASE_GAP(3), .READY_MASK(2'b00),
    .RDY_TIMEOUT(20), .ACTIVE_LOW_MASK(2'b10)
  ) u_a (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rstn_a),
    .bus          (ifa.slave)
  );

  jesd204_reset_sequencer #(
    .NUM_CH(2), .PULSE_LEN(8), .CNT_W(16),
    .RELEASE_GAP(3), .READY_MASK(2'b01),
    .RDY_TIMEOUT(20), .ACTIVE_LOW_MASK(2'b10)
  ) u_b (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rstn_b),
    .bus          (ifb.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // t=1 is the first edge; 0 means "never seen".
  task automatic watch(input  bit sel,
                       input  int n,
                       input  int rdy_at,
                       output int t0,
                       output int t1,
                       output int td,
                       output int tnb,
                       output int te,
                       output int nd);
    logic [1:0] ro;
    logic [1:0] er;
    logic       bz;
    logic       sd;
    t0 = 0; t1 = 0; td = 0;
    tnb = 0; te = 0; nd = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      ro = sel ? ifb.rst_out     : ifa.rst_out;
      er = sel ? ifb.timeout_err : ifa.timeout_err;
      bz = sel ? ifb.busy        : ifa.busy;
      sd = sel ? ifb.seq_done    : ifa.seq_done;
      if (t0 == 0 && ro[0] == 1'b0) t0 = t;
      if (t1 == 0 && ro[1] == 1'b1) t1 = t;
      if (sd) begin
        nd++;
        if (td == 0) td = t;
      end
      if (tnb == 0 && !bz) tnb = t;
      if (te == 0 && er[0]) te = t;
      if (t == rdy_at) ifb.ch_ready[0] = 1'b1;
    end
  endtask

  initial begin
    int t0, t1, td, tnb, te, nd;
    int hi, rises, c1, bzc, pre;
    logic prev;

    rstn_a = 1'b0;
    rstn_b = 1'b0;
    ifa.master_reset = 1'b0;
    ifa.ch_reset     = 2'b00;
    ifa.ch_ready     = 2'b00;
    ifb.master_reset = 1'b0;
    ifb.ch_reset     = 2'b00;
    ifb.ch_ready     = 2'b10;
    repeat (3) tick();

    chk("a_rst_out",  ifa.rst_out, 2'b01);
    chk("a_rst_busy", ifa.busy, 1);
    chk("a_rst_done", ifa.seq_done, 0);
    chk("a_rst_terr", ifa.timeout_err, 0);

    // power-on sequence
    rstn_a = 1'b1;
    watch(1'b0, 40, 0, t0, t1, td, tnb, te, nd);
    chk("a_por_ch0",    t0, 9);
    chk("a_por_ch1",    t1, 12);
    chk("a_por_done_t", td, 13);
    chk("a_por_done_n", nd, 1);
    chk("a_por_busy",   tnb, 14);

    // single channel pulse, request held high
    ifa.ch_reset = 2'b01;
    hi = 0; rises = 0; c1 = 0; bzc = 0;
    prev = 1'b0;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (ifa.rst_out[0]) hi++;
      if (ifa.rst_out[0] && !prev) rises++;
      prev = ifa.rst_out[0];
      if (ifa.rst_out[1] !== 1'b1) c1++;
      if (ifa.busy) bzc++;
    end
    ifa.ch_reset = 2'b00;
    chk("a_pls_len",   hi, 8);
    chk("a_pls_count", rises, 1);
    chk("a_pls_ch1",   c1, 0);
    chk("a_pls_busy",  bzc, 0);

    // second edge mid-pulse restarts the full length
    hi = 0;
    for (int t = 0; t < 30; t++) begin
      ifa.ch_reset[1] = (t == 0 || t == 3);
      tick();
      if (!ifa.rst_out[1]) hi++;
    end
    chk("a_pls_restart", hi, 11);

    // master edge while in GAP
    ifa.master_reset = 1'b1;
    pre = 0;
    for (int s = 1; s <= 10; s++) begin
      tick();
      if (ifa.seq_done) pre++;
      if (s == 2) ifa.master_reset = 1'b0;
    end
    chk("a_gap_ch0_rel",  ifa.rst_out[0], 0);
    chk("a_gap_ch1_held", ifa.rst_out[1], 0);
    ifa.master_reset = 1'b1;
    tick();
    chk("a_gap_reassert", ifa.rst_out, 2'b01);
    watch(1'b0, 30, 0, t0, t1, td, tnb, te, nd);
    chk("a_gap_ch0",    t0, 8);
    chk("a_gap_ch1",    t1, 11);
    chk("a_gap_done_t", td, 12);
    chk("a_gap_done_n", pre + nd, 1);
    chk("a_gap_busy",   tnb, 13);

    // simultaneous master and channel edge, busy ignores channel
    ifa.master_reset = 1'b0;
    tick();
    ifa.master_reset = 1'b1;
    ifa.ch_reset     = 2'b01;
    tick();
    chk("a_sim_busy", ifa.busy, 1);
    chk("a_sim_rst",  ifa.rst_out, 2'b01);
    ifa.ch_reset = 2'b00;
    watch(1'b0, 9, 0, t0, t1, td, tnb, te, nd);
    chk("a_sim_ch0", t0, 8);
    ifa.ch_reset = 2'b01;
    tick();
    chk("a_busy_ign", ifa.rst_out[0], 0);
    repeat (10) tick();
    chk("a_sim_end",  ifa.rst_out, 2'b10);
    chk("a_sim_idle", ifa.busy, 0);
    ifa.ch_reset = 2'b00;

    // ready wait satisfied 5 cycles after ch0 release
    chk("b_rst_out", ifb.rst_out, 2'b01);
    rstn_b = 1'b1;
    watch(1'b1, 40, 13, t0, t1, td, tnb, te, nd);
    chk("b_rdy_ch0",    t0, 9);
    chk("b_rdy_ch1",    t1, 17);
    chk("b_rdy_done_t", td, 18);
    chk("b_rdy_done_n", nd, 1);
    chk("b_rdy_terr",   ifb.timeout_err, 0);

    // ready never arrives: timeout flag, sequence completes
    ifb.ch_ready     = 2'b00;
    ifb.master_reset = 1'b1;
    watch(1'b1, 40, 0, t0, t1, td, tnb, te, nd);
    chk("b_to_ch0",    t0, 9);
    chk("b_to_terr_t", te, 30);
    chk("b_to_ch1",    t1, 33);
    chk("b_to_done_t", td, 34);
    chk("b_to_done_n", nd, 1);
    chk("b_to_sticky", ifb.timeout_err, 2'b01);

    // next master edge clears the flag
    ifb.master_reset = 1'b0;
    tick();
    ifb.master_reset = 1'b1;
    tick();
    chk("b_terr_clear", ifb.timeout_err, 0);
    repeat (14) tick();
    chk("b_wait_state", ifb.rst_out, 2'b00);
    chk("b_wait_busy",  ifb.busy, 1);

    // block reset in WAIT_RDY
    rstn_b = 1'b0;
    tick();
    chk("b_mid_rst_out",  ifb.rst_out, 2'b01);
    chk("b_mid_rst_busy", ifb.busy, 1);
    chk("b_mid_rst_terr", ifb.timeout_err, 0);
    rstn_b = 1'b1;
    watch(1'b1, 40, 0, t0, t1, td, tnb, te, nd);
    chk("b_rerun_ch0",    t0, 9);
    chk("b_rerun_terr_t", te, 30);
    chk("b_rerun_ch1",    t1, 33);
    chk("b_rerun_done_n", nd, 1);

    // reset clears a set flag
    rstn_b = 1'b0;
    tick();
    chk("b_rst_terr_clr", ifb.timeout_err, 0);
    rstn_b = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
